// File: rtl/arashi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arashi_pkg                                                   |
// | Description : Shared widths, helper functions and return-tag type for the  |
// |               arashi thread read path.                                     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package arashi_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int tid_w(input int thread_num);
        return clog2(thread_num);
    endfunction

    function automatic int off_w(input int mem_width, input int thread_num);
        return mem_width - clog2(thread_num);
    endfunction

    localparam int c_THREAD_NUM = 4;
    localparam int c_MEM_WIDTH  = 10;
    localparam int c_TID_W      = tid_w(c_THREAD_NUM);
    localparam int c_OFF_W      = off_w(c_MEM_WIDTH, c_THREAD_NUM);

    // Tag is sized for the largest supported thread count so one type serves every build.
    localparam int c_TID_MAX_W  = 4;

    typedef struct packed {
        logic                   vld;
        logic [c_TID_MAX_W-1:0] tid;
    } rtag_t;

endpackage
`default_nettype wire

// File: rtl/arashi_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arashi_rr_arbiter                                            |
// | Description : Round-robin arbiter, one-hot grant plus index; N must be a   |
// |               power of two (>= 2). Pointer moves past the winner on adv.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module arashi_rr_arbiter
    import arashi_pkg::*;
#(
    parameter  int N      = 4,
    localparam int c_ID_W = clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic              adv,
    output logic [N-1:0]      gnt,
    output logic [c_ID_W-1:0] gnt_id
);

    logic [c_ID_W-1:0] r_ptr;
    logic [c_ID_W-1:0] w_idx;
    logic [N-1:0]      w_gnt;
    logic [c_ID_W-1:0] w_id;

    // Scan from the farthest candidate back to r_ptr so the closest requester wins last.
    always_comb begin
        w_gnt = '0;
        w_id  = '0;
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = r_ptr + c_ID_W'(i);
            if (req[w_idx]) begin
                w_gnt        = '0;
                w_gnt[w_idx] = 1'b1;
                w_id         = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (adv && (|req)) begin
            r_ptr <= w_id + c_ID_W'(1);
        end
    end

    assign gnt    = w_gnt;
    assign gnt_id = w_id;

endmodule
`default_nettype wire

// File: rtl/arashi_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arashi_reader                                                |
// | Description : Per-thread in-order reader: round-robin onto one memory read |
// |               port, data steered back to the requesting thread's lane.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module arashi_reader
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WIDTH  = 10,
    parameter int THREAD_NUM = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [THREAD_NUM-1:0]            rd,
    input  logic [THREAD_NUM-1:0]            wr_cmt,
    output logic                             mem_ren,
    output logic [MEM_WIDTH-1:0]             mem_raddr,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic [DATA_WIDTH*THREAD_NUM-1:0] out,
    output logic [THREAD_NUM-1:0]            out_vld,
    output logic [THREAD_NUM-1:0]            empty,
    output logic [THREAD_NUM-1:0]            rd_err
);

    localparam int c_TID_W = tid_w(THREAD_NUM);
    localparam int c_OFF_W = off_w(MEM_WIDTH, THREAD_NUM);
    localparam int c_DEPTH = 1 << c_OFF_W;

    localparam logic [c_OFF_W:0]   c_CNT_FULL = (c_OFF_W + 1)'(c_DEPTH);
    localparam logic [c_OFF_W:0]   c_CNT_ONE  = (c_OFF_W + 1)'(1);
    localparam logic [c_OFF_W-1:0] c_PTR_ONE  = c_OFF_W'(1);

    if ((THREAD_NUM < 4) || (THREAD_NUM > 16) || ((THREAD_NUM & (THREAD_NUM - 1)) != 0)) begin : g_bad_thread_num
        $error("arashi_reader: THREAD_NUM must be a power of two in 4..16");
    end

    logic [c_OFF_W-1:0]              r_rptr    [THREAD_NUM];
    logic [c_OFF_W:0]                r_cnt     [THREAD_NUM];
    logic [c_OFF_W:0]                w_cnt_nxt [THREAD_NUM];
    logic [THREAD_NUM-1:0]           r_pend;
    logic [THREAD_NUM-1:0]           r_empty;
    logic [THREAD_NUM-1:0]           r_rd_err;
    logic [THREAD_NUM-1:0]           w_elig;
    logic [THREAD_NUM-1:0]           w_gnt;
    logic [c_TID_W-1:0]              w_gnt_id;
    logic                            w_any_gnt;

    logic                            r_mem_ren;
    logic [MEM_WIDTH-1:0]            r_mem_raddr;
    rtag_t                           r_tag1;
    rtag_t                           r_tag2;
    logic [DATA_WIDTH*THREAD_NUM-1:0] r_out;
    logic [THREAD_NUM-1:0]           r_out_vld;

    // Eligibility uses registered occupancy only; a same-cycle commit counts next cycle.
    always_comb begin
        w_elig = '0;
        for (int t = 0; t < THREAD_NUM; t++) begin
            w_elig[t] = r_pend[t] && (r_cnt[t] != '0);
        end
    end

    arashi_rr_arbiter #(
        .N (THREAD_NUM)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (w_elig),
        .adv    (1'b1),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign w_any_gnt = |w_gnt;

    // Commit and grant together cancel; a commit into a full region is dropped.
    always_comb begin
        for (int t = 0; t < THREAD_NUM; t++) begin
            w_cnt_nxt[t] = r_cnt[t];
            if (wr_cmt[t] && !w_gnt[t]) begin
                if (r_cnt[t] != c_CNT_FULL) begin
                    w_cnt_nxt[t] = r_cnt[t] + c_CNT_ONE;
                end
            end else if (w_gnt[t] && !wr_cmt[t]) begin
                w_cnt_nxt[t] = r_cnt[t] - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < THREAD_NUM; t++) begin
                r_rptr[t] <= '0;
                r_cnt[t]  <= '0;
            end
            r_pend   <= '0;
            r_empty  <= '1;
            r_rd_err <= '0;
        end else begin
            for (int t = 0; t < THREAD_NUM; t++) begin
                r_cnt[t] <= w_cnt_nxt[t];
                if (w_gnt[t]) begin
                    r_rptr[t] <= r_rptr[t] + c_PTR_ONE;
                end
            end
            // A new request in the grant cycle re-arms pend instead of being dropped.
            r_pend   <= rd | (r_pend & ~w_gnt);
            r_rd_err <= rd & r_pend & ~w_gnt;
            for (int t = 0; t < THREAD_NUM; t++) begin
                r_empty[t] <= (w_cnt_nxt[t] == '0);
            end
        end
    end

    // Tag travels with mem_ren, then one more stage to line up with mem_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_ren   <= 1'b0;
            r_mem_raddr <= '0;
            r_tag1      <= '0;
            r_tag2      <= '0;
            r_out       <= '0;
            r_out_vld   <= '0;
        end else begin
            r_mem_ren <= w_any_gnt;
            if (w_any_gnt) begin
                r_mem_raddr <= {w_gnt_id, r_rptr[w_gnt_id]};
            end
            r_tag1.vld <= w_any_gnt;
            r_tag1.tid <= c_TID_MAX_W'(w_gnt_id);
            r_tag2     <= r_tag1;
            for (int t = 0; t < THREAD_NUM; t++) begin
                r_out_vld[t] <= r_tag2.vld && (r_tag2.tid == c_TID_MAX_W'(t));
                if (r_tag2.vld && (r_tag2.tid == c_TID_MAX_W'(t))) begin
                    r_out[t*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                end
            end
        end
    end

    assign mem_ren   = r_mem_ren;
    assign mem_raddr = r_mem_raddr;
    assign out       = r_out;
    assign out_vld   = r_out_vld;
    assign empty     = r_empty;
    assign rd_err    = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_arashi_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_arashi_reader                                             |
// | Description : Scoreboard bench for arashi_reader with a 1-cycle memory.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_arashi_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rd;
    logic [3:0]   wr_cmt;
    logic         mem_ren;
    logic [9:0]   mem_raddr;
    logic [31:0]  mem_rdata = '0;
    logic [127:0] out;
    logic [3:0]   out_vld;
    logic [3:0]   empty;
    logic [3:0]   rd_err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [33:0] exp_q[$];
    logic [9:0]  addr_q[$];

    arashi_reader #(
        .DATA_WIDTH (32),
        .MEM_WIDTH  (10),
        .THREAD_NUM (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd        (rd),
        .wr_cmt    (wr_cmt),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .out       (out),
        .out_vld   (out_vld),
        .empty     (empty),
        .rd_err    (rd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [9:0] a);
        return {16'hC0DE, 6'd0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_ren) begin
            mem_rdata <= memval(mem_raddr);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_read(input int tid, input logic [9:0] addr);
        addr_q.push_back(addr);
        exp_q.push_back({2'(tid), memval(addr)});
    endtask

    // Monitor: every read issue and every returned word is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_ren) begin
                if (addr_q.size() == 0) begin
                    check("spurious_mem_ren", {63'd0, mem_ren}, 64'd0);
                end else begin
                    check("mem_raddr", {54'd0, mem_raddr}, {54'd0, addr_q.pop_front()});
                end
            end
            for (int t = 0; t < 4; t++) begin
                if (out_vld[t]) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out_vld", {60'd0, out_vld}, 64'd0);
                    end else begin
                        check("out_lane", {30'd0, 2'(t), out[t*32 +: 32]}, {30'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_ren"},   {63'd0, mem_ren},   64'd0);
        check({tag, "_mem_raddr"}, {54'd0, mem_raddr}, 64'd0);
        check({tag, "_out_nz"},    {63'd0, |out},      64'd0);
        check({tag, "_out_vld"},   {60'd0, out_vld},   64'd0);
        check({tag, "_rd_err"},    {60'd0, rd_err},    64'd0);
        check({tag, "_empty"},     {60'd0, empty},     64'hF);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        rd     = '0;
        wr_cmt = '0;
        exp_q.delete();
        addr_q.delete();
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        check("drain_out_pending", 64'(exp_q.size()), 64'd0);
        repeat (4) tick();
    endtask

    initial begin
        logic [3:0] err_acc;
        rst    = 1'b1;
        rd     = '0;
        wr_cmt = '0;

        // Single-thread latency and occupancy.
        do_reset();
        wr_cmt = 4'b0001;
        repeat (3) tick();
        wr_cmt = '0;
        expect_read(0, 10'h000);
        rd = 4'b0001;
        tick();
        rd = '0;
        check("t1_no_ren_yet", {63'd0, mem_ren}, 64'd0);
        tick();
        check("t1_ren", {63'd0, mem_ren}, 64'd1);
        check("t1_raddr", {54'd0, mem_raddr}, 64'h000);
        tick();
        check("t1_vld_early", {60'd0, out_vld}, 64'd0);
        tick();
        check("t1_vld", {60'd0, out_vld}, 64'b0001);
        check("t1_data", {32'd0, out[31:0]}, {32'd0, memval(10'h000)});
        check("t1_not_empty", {63'd0, empty[0]}, 64'd0);
        expect_read(0, 10'h001);
        rd = 4'b0001;
        tick();
        rd = '0;
        tick();
        expect_read(0, 10'h002);
        rd = 4'b0001;
        tick();
        rd = '0;
        drain();
        check("t1_empty_after", {63'd0, empty[0]}, 64'd1);

        // All threads at once: round-robin order on consecutive cycles.
        do_reset();
        wr_cmt = 4'b1111;
        tick();
        wr_cmt = '0;
        for (int t = 0; t < 4; t++) expect_read(t, 10'(t << 8));
        rd = 4'b1111;
        tick();
        rd = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_ren", {63'd0, mem_ren}, 64'd1);
            check("t2_raddr", {54'd0, mem_raddr}, 64'(i << 8));
        end
        drain();
        check("t2_empty", {60'd0, empty}, 64'hF);

        // Request waits on an empty region until a commit arrives.
        do_reset();
        rd = 4'b0100;
        tick();
        rd = '0;
        repeat (5) begin
            check("t3_no_ren", {63'd0, mem_ren}, 64'd0);
            tick();
        end
        expect_read(2, 10'h200);
        wr_cmt = 4'b0100;
        tick();
        wr_cmt = '0;
        check("t3_not_empty", {63'd0, empty[2]}, 64'd0);
        check("t3_no_ren_cmt", {63'd0, mem_ren}, 64'd0);
        tick();
        check("t3_ren", {63'd0, mem_ren}, 64'd1);
        check("t3_raddr", {54'd0, mem_raddr}, 64'h200);
        tick();
        tick();
        check("t3_vld", {60'd0, out_vld}, 64'b0100);
        drain();

        // Duplicate request while pending is dropped with a single error pulse.
        do_reset();
        rd = 4'b0010;
        tick();
        rd = 4'b0010;
        tick();
        rd = '0;
        check("t4_rd_err", {60'd0, rd_err}, 64'b0010);
        tick();
        check("t4_rd_err_clear", {60'd0, rd_err}, 64'd0);
        expect_read(1, 10'h100);
        wr_cmt = 4'b0010;
        tick();
        wr_cmt = '0;
        drain();
        check("t4_empty", {63'd0, empty[1]}, 64'd1);

        // Thread 3 wrap: full region (extra commit ignored), back-to-back reads, then wrap.
        do_reset();
        wr_cmt = 4'b1000;
        repeat (257) tick();
        wr_cmt = '0;
        for (int i = 0; i < 256; i++) expect_read(3, 10'h300 + 10'(i));
        rd      = 4'b1000;
        err_acc = '0;
        repeat (256) begin
            tick();
            err_acc |= rd_err;
        end
        rd = '0;
        drain();
        check("t5_no_rd_err", {60'd0, err_acc}, 64'd0);
        check("t5_empty_sat", {63'd0, empty[3]}, 64'd1);
        expect_read(3, 10'h300);
        wr_cmt = 4'b1000;
        tick();
        wr_cmt = '0;
        rd = 4'b1000;
        tick();
        rd = '0;
        drain();

        // Reset with two reads in flight discards them.
        do_reset();
        wr_cmt = 4'b0011;
        tick();
        wr_cmt = '0;
        expect_read(0, 10'h000);
        expect_read(1, 10'h100);
        rd = 4'b0011;
        tick();
        rd = '0;
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        #1;
        check_reset_outputs("t6_async");
        tick();
        tick();
        rst = 1'b0;
        repeat (6) begin
            tick();
            check("t6_no_vld", {60'd0, out_vld}, 64'd0);
        end
        check("t6_empty", {60'd0, empty}, 64'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
